io_page_writer: RTL and testbench

IO_PAGE_WRITER -- requirements
Module: io_page_writer

---
 rtl/io_page_writer.sv | 156 +++++++++++++++
 tb/tb_io_page_writer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_page_writer.sv
// io_page_writer
//   Moves the last received UART key byte and a periodically refreshed
//   random byte into two fixed RAM locations. The writes use the shared
//   RAM write port, which is borrowed from the CPU through a request/grant
//   pair.
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   reset        in   synchronous, active-high reset
//   rx_valid     in   one-cycle strobe, rx_data holds a received byte
//   rx_data      in   [7:0] received byte
//   grant        in   RAM write port belongs to this block
//   ask_for_ram  out  request for the RAM write port
//   waddr        out  [10:0] RAM write address (0 when idle)
//   wdata        out  [7:0] RAM write data (0 when idle)
//   write_en     out  one-cycle RAM write strobe
//   overrun      out  sticky: a key byte was lost before reaching RAM
//   dbg_state_o  out  [2:0] current FSM state, for observation only
//
// Handshake: ask_for_ram is a level request. Once grant is seen high in
// REQ the burst runs to completion, regardless of grant, because the
// arbiter keeps the CPU paused until ask_for_ram falls. ask_for_ram always
// drops for one RELEASE cycle before a new request can be raised.
module io_page_writer #(
  parameter int unsigned RAND_PERIOD = 420000,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter logic [10:0] KEY_ADDR    = 11'h0FF,
  parameter logic [10:0] RND_ADDR    = 11'h0FE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        grant,
  output logic        ask_for_ram,
  output logic [10:0] waddr,
  output logic [7:0]  wdata,
  output logic        write_en,
  output logic        overrun,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WR_KEY  = 3'd2,
    S_WR_RND  = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  localparam logic [23:0] PERIOD_LAST = 24'(RAND_PERIOD - 1);

  state_e      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [23:0] cnt_q;
  logic        key_pending_q, rnd_pending_q;
  logic [7:0]  key_byte_q, rnd_byte_q;
  logic        overrun_q;

  logic wrap;
  logic key_clr;
  logic rnd_clr;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1: feedback from stages 8,6,5,4.
  assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign wrap    = (cnt_q == PERIOD_LAST);
  assign key_clr = (state_q == S_WR_KEY);
  assign rnd_clr = (state_q == S_WR_RND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending flags: a new byte in the same cycle as its write keeps the flag
  // set, so the newer byte is written in a later burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q        <= LFSR_SEED;
      cnt_q         <= '0;
      key_pending_q <= 1'b0;
      rnd_pending_q <= 1'b0;
      key_byte_q    <= '0;
      rnd_byte_q    <= '0;
      overrun_q     <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= wrap ? '0 : cnt_q + 24'd1;

      if (rx_valid) begin
        key_pending_q <= 1'b1;
        key_byte_q    <= rx_data;
        if (key_pending_q && !key_clr) begin
          overrun_q <= 1'b1;
        end
      end else if (key_clr) begin
        key_pending_q <= 1'b0;
      end

      if (wrap) begin
        rnd_pending_q <= 1'b1;
        rnd_byte_q    <= lfsr_q;
      end else if (rnd_clr) begin
        rnd_pending_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ask_for_ram = 1'b0;
    write_en    = 1'b0;
    waddr       = '0;
    wdata       = '0;
    case (state_q)
      S_IDLE: begin
        if (key_pending_q || rnd_pending_q) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        ask_for_ram = 1'b1;
        if (grant) begin
          state_d = key_pending_q ? S_WR_KEY : S_WR_RND;
        end
      end
      S_WR_KEY: begin
        ask_for_ram = 1'b1;
        write_en    = 1'b1;
        waddr       = KEY_ADDR;
        wdata       = key_byte_q;
        state_d     = rnd_pending_q ? S_WR_RND : S_RELEASE;
      end
      S_WR_RND: begin
        ask_for_ram = 1'b1;
        write_en    = 1'b1;
        waddr       = RND_ADDR;
        wdata       = rnd_byte_q;
        state_d     = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_io_page_writer.sv
// Testbench for io_page_writer: randomized key/grant/reset traffic plus a
// few directed scenarios, checked by a scoreboard against a reference model
// of the pending key and random bytes.
module tb_io_page_writer;

  localparam int          P        = 16;
  localparam logic [7:0]  SEED     = 8'hA5;
  localparam logic [10:0] KEY_A    = 11'h0FF;
  localparam logic [10:0] RND_A    = 11'h0FE;

  // Clock/reset block
  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        grant;
  logic        ask_for_ram;
  logic [10:0] waddr;
  logic [7:0]  wdata;
  logic        write_en;
  logic        overrun;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  io_page_writer #(
    .RAND_PERIOD(P),
    .LFSR_SEED  (SEED),
    .KEY_ADDR   (KEY_A),
    .RND_ADDR   (RND_A)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .grant      (grant),
    .ask_for_ram(ask_for_ram),
    .waddr      (waddr),
    .wdata      (wdata),
    .write_en   (write_en),
    .overrun    (overrun),
    .dbg_state_o(dbg_state)
  );

  // Reference model state: bytes not yet written to RAM (at most one each,
  // newest wins), the sticky overrun, a cycle count since reset and the
  // random-number generator value for the current cycle.
  logic [7:0] key_q[$];
  logic [7:0] rnd_q[$];
  bit         m_ovr = 1'b0;
  int         k = 0;
  logic [7:0] m_lfsr = SEED;
  bit         rst_chk = 1'b0;
  bit         prev_we = 1'b0;
  int         key_writes = 0;
  int         rnd_writes = 0;

  int checks = 0;
  int errors = 0;

  // Next value of an 8-bit Fibonacci generator for x^8+x^6+x^5+x^4+1,
  // computed from the list of tap stages.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    int   taps[4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    for (int i = 0; i < 4; i++) fb = fb ^ s[taps[i] - 1];
    return {s[6:0], fb};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=write required=no_write", name);
  endtask

  // Driver: applies one cycle of inputs just after the falling edge and
  // updates the model with what that cycle will cause.
  task automatic tick(input logic rv, input logic [7:0] rd, input logic g, input logic rst);
    @(negedge clk);
    #1;
    rx_valid = rst ? 1'b0 : rv;
    rx_data  = rd;
    grant    = g;
    reset    = rst;
    if (rst) begin
      key_q.delete();
      rnd_q.delete();
      m_ovr   = 1'b0;
      m_lfsr  = SEED;
      k       = 0;
      rst_chk = 1'b1;
    end else begin
      if (rv) begin
        if (key_q.size() > 0) begin
          key_q[0] = rd;
          m_ovr    = 1'b1;
        end else begin
          key_q.push_back(rd);
        end
      end
      if (k % P == P - 1) begin
        if (rnd_q.size() > 0) rnd_q[0] = m_lfsr;
        else rnd_q.push_back(m_lfsr);
      end
      m_lfsr = lfsr_next(m_lfsr);
      k++;
    end
  endtask

  task automatic idle(input int n, input logic g);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, g, 1'b0);
  endtask

  // Monitor / scoreboard: samples outputs at the falling edge.
  always @(negedge clk) begin
    if (rst_chk) begin
      chk("rst_ask", 32'(ask_for_ram), 32'd0);
      chk("rst_we", 32'(write_en), 32'd0);
      chk("rst_waddr", 32'(waddr), 32'd0);
      chk("rst_wdata", 32'(wdata), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      rst_chk = 1'b0;
    end
    if (write_en === 1'b1) begin
      chk("write_ask", 32'(ask_for_ram), 32'd1);
      if (waddr == KEY_A) begin
        if (key_q.size() == 0) fail_now("key_unexpected");
        else chk("key_data", 32'(wdata), 32'(key_q.pop_front()));
        key_writes++;
      end else if (waddr == RND_A) begin
        chk("rnd_nonzero", 32'(wdata == 8'h00), 32'd0);
        if (rnd_q.size() == 0) fail_now("rnd_unexpected");
        else chk("rnd_data", 32'(wdata), 32'(rnd_q.pop_front()));
        rnd_writes++;
      end else begin
        chk("waddr_legal", 32'(waddr), 32'(KEY_A));
      end
    end else begin
      chk("idle_we", 32'(write_en), 32'd0);
      chk("idle_waddr", 32'(waddr), 32'd0);
      chk("idle_wdata", 32'(wdata), 32'd0);
      if (prev_we) chk("release_ask", 32'(ask_for_ram), 32'd0);
    end
    chk("overrun", 32'(overrun), 32'(m_ovr));
    prev_we = (write_en === 1'b1);
  end

  bit g_mode;
  int drain;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    grant    = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);

    // Key with grant tied high.
    tick(1'b1, 8'h77, 1'b1, 1'b0);
    idle(10, 1'b1);

    // Key held off by grant=0 for 50 cycles, random byte also becomes pending.
    tick(1'b1, 8'h41, 1'b0, 1'b0);
    idle(4, 1'b0);
    for (int i = 0; i < 46; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      chk("hold_ask", 32'(ask_for_ram), 32'd1);
      chk("hold_we", 32'(write_en), 32'd0);
    end
    idle(10, 1'b1);

    // Two keys while blocked: overrun, only the second written.
    tick(1'b1, 8'h31, 1'b0, 1'b0);
    idle(3, 1'b0);
    tick(1'b1, 8'h32, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(20, 1'b1);

    // Reset during the key write cycle.
    idle(5, 1'b0);
    tick(1'b1, 8'h5A, 1'b0, 1'b0);
    idle(5, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    idle(12, 1'b1);

    // Randomized traffic.
    g_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) g_mode = ~g_mode;
      if ($urandom_range(0, 399) == 0) begin
        tick(1'b0, 8'h00, 1'b0, 1'b1);
      end else begin
        tick(($urandom_range(0, 11) == 0), 8'($urandom_range(0, 255)),
             g_mode ? ($urandom_range(0, 3) != 0) : 1'b0, 1'b0);
      end
    end

    // Drain with grant high, bounded.
    drain = 0;
    while (key_q.size() != 0 && drain < 200) begin
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      drain++;
    end
    chk("drain_key", 32'(key_q.size()), 32'd0);
    chk("key_writes_seen", 32'(key_writes > 20), 32'd1);
    chk("rnd_writes_seen", 32'(rnd_writes > 20), 32'd1);
    idle(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
